// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared counter encodings, defaults and saturating update for the gshare predictor
package branch_pred_pkg;

    localparam int DEF_PC_W  = 5;
    localparam int DEF_GHR_W = 5;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        STK = 2'b11
    } ctr_e;

    localparam ctr_e PHT_RESET = WNT;

    function automatic ctr_e ctr_train(input ctr_e c, input logic taken);
        ctr_e r;
        if (taken) begin
            r = (c == STK) ? STK : ctr_e'(c + 2'd1);
        end else begin
            r = (c == SNT) ? SNT : ctr_e'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - 2-bit saturating counter array with one combinational read and one train port
module gshare_pht
    import branch_pred_pkg::*;
#(
    parameter int GHR_W = DEF_GHR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [GHR_W-1:0] i_rd_idx,
    output ctr_e             o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [GHR_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int DEPTH = 1 << GHR_W;

    ctr_e r_pht [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pht[i] <= PHT_RESET;
            end
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= ctr_train(r_pht[i_wr_idx], i_wr_taken);
        end
    end

    // Read returns the stored value; a same-cycle write lands on the next edge.
    assign o_rd_ctr = r_pht[i_rd_idx];

endmodule

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare direction predictor with direct-mapped BTB and repairable global history
module branch_predictor_gshare
    import branch_pred_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int GHR_W = DEF_GHR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_F,
    input  logic [PC_W-1:0]  PC_F,
    output logic             prediction_F,
    output logic [PC_W-1:0]  BTA_F,
    output logic [GHR_W-1:0] ghr_F,
    input  logic             update_signal_E,
    input  logic [PC_W-1:0]  PC_E,
    input  logic [GHR_W-1:0] ghr_E,
    input  logic             taken_E,
    input  logic [PC_W-1:0]  target_E,
    input  logic             mispredict_E
);

    localparam int BTB_DEPTH = 1 << PC_W;

    logic            r_btb_valid  [BTB_DEPTH];
    logic [PC_W-1:0] r_btb_target [BTB_DEPTH];
    logic [GHR_W-1:0] r_ghr;

    logic [GHR_W-1:0] w_idx_f;
    logic [GHR_W-1:0] w_idx_e;
    logic             w_hit;
    ctr_e             w_ctr_f;
    logic [GHR_W-1:0] w_ghr_next;

    assign w_idx_f = PC_F[GHR_W-1:0] ^ r_ghr;
    assign w_idx_e = PC_E[GHR_W-1:0] ^ ghr_E;
    assign w_hit   = r_btb_valid[PC_F];

    gshare_pht #(
        .GHR_W (GHR_W)
    ) u_pht (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_idx_f),
        .o_rd_ctr   (w_ctr_f),
        .i_wr_en    (update_signal_E),
        .i_wr_idx   (w_idx_e),
        .i_wr_taken (taken_E)
    );

    assign prediction_F = w_hit & w_ctr_f[1];
    assign BTA_F        = r_btb_target[PC_F];
    assign ghr_F        = r_ghr;

    // Repair from the resolved branch's own snapshot outranks any speculative shift.
    always_comb begin
        w_ghr_next = r_ghr;
        if (update_signal_E && mispredict_E) begin
            w_ghr_next = (ghr_E << 1) | GHR_W'(taken_E);
        end else if (!stall_F && w_hit) begin
            w_ghr_next = (r_ghr << 1) | GHR_W'(prediction_F);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

    // Not-taken outcomes leave the BTB alone so a cold loop exit keeps its target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_target[i] <= '0;
            end
        end else if (update_signal_E && taken_E) begin
            r_btb_valid[PC_E]  <= 1'b1;
            r_btb_target[PC_E] <= target_E;
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - directed self-checking bench for branch_predictor_gshare
module tb_branch_predictor_gshare;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall_F;
    logic [4:0] PC_F;
    logic       prediction_F;
    logic [4:0] BTA_F;
    logic [4:0] ghr_F;
    logic       update_signal_E;
    logic [4:0] PC_E;
    logic [4:0] ghr_E;
    logic       taken_E;
    logic [4:0] target_E;
    logic       mispredict_E;

    int checks   = 0;
    int failures = 0;

    branch_predictor_gshare #(
        .PC_W  (5),
        .GHR_W (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_F         (stall_F),
        .PC_F            (PC_F),
        .prediction_F    (prediction_F),
        .BTA_F           (BTA_F),
        .ghr_F           (ghr_F),
        .update_signal_E (update_signal_E),
        .PC_E            (PC_E),
        .ghr_E           (ghr_E),
        .taken_E         (taken_E),
        .target_E        (target_E),
        .mispredict_E    (mispredict_E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [4:0] pc, input logic [4:0] gh, input logic tk,
                         input logic [4:0] tgt, input logic mp);
        update_signal_E = 1'b1;
        PC_E            = pc;
        ghr_E           = gh;
        taken_E         = tk;
        target_E        = tgt;
        mispredict_E    = mp;
    endtask

    task automatic idle_e();
        update_signal_E = 1'b0;
        mispredict_E    = 1'b0;
        taken_E         = 1'b0;
        PC_E            = '0;
        ghr_E           = '0;
        target_E        = '0;
    endtask

    initial begin
        reset   = 1'b1;
        stall_F = 1'b0;
        PC_F    = 5'd5;
        idle_e();
        #2;
        chk("reset_pred", prediction_F, 0);
        chk("reset_bta",  BTA_F, 0);
        chk("reset_ghr",  ghr_F, 0);
        tick();
        reset = 1'b0;

        // First taken training of PC 5 with repair to GHR=00001
        train(5'd5, 5'd0, 1'b1, 5'd20, 1'b1);
        tick();
        idle_e();
        #1;
        chk("idx4_pred", prediction_F, 0);
        chk("idx4_bta",  BTA_F, 20);
        chk("idx4_ghr",  ghr_F, 1);

        // Repair back to GHR=0 (not-taken, idx 31 drops 01->00)
        train(5'd31, 5'd0, 1'b0, 5'd0, 1'b1);
        tick();
        idle_e();
        #1;
        chk("idx5_pred", prediction_F, 1);
        chk("idx5_bta",  BTA_F, 20);
        chk("idx5_ghr",  ghr_F, 0);

        // Speculative shift gated by stall, then taken, then a miss
        stall_F = 1'b1;
        tick();
        chk("stall_hold_ghr", ghr_F, 0);
        stall_F = 1'b0;
        tick();
        chk("spec_shift_ghr", ghr_F, 1);
        PC_F = 5'd9;
        #1;
        chk("miss_pred", prediction_F, 0);
        tick();
        chk("miss_hold_ghr", ghr_F, 1);

        // Repair priority over a same-cycle speculative shift
        train(5'd31, 5'd0, 1'b0, 5'd0, 1'b1);
        tick();
        idle_e();
        PC_F = 5'd5;
        #1;
        chk("prio_pre_pred", prediction_F, 1);
        train(5'd10, 5'b01010, 1'b0, 5'd0, 1'b1);
        tick();
        idle_e();
        chk("prio_repair_ghr", ghr_F, 5'b10100);

        // Saturation on idx 3 with GHR forced to 0 and fetch stalled
        train(5'd31, 5'd0, 1'b0, 5'd0, 1'b1);
        tick();
        stall_F = 1'b1;
        PC_F    = 5'd3;
        for (int i = 0; i < 4; i++) begin
            train(5'd3, 5'd0, 1'b1, 5'd12, 1'b0);
            tick();
        end
        idle_e();
        #1;
        chk("sat_hi_pred", prediction_F, 1);
        chk("sat_hi_bta",  BTA_F, 12);
        train(5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle_e();
        chk("sat_wt_pred", prediction_F, 1);
        for (int i = 0; i < 4; i++) begin
            train(5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        idle_e();
        chk("sat_lo_pred", prediction_F, 0);
        chk("nt_keeps_btb", BTA_F, 12);
        train(5'd3, 5'd0, 1'b1, 5'd12, 1'b0);
        tick();
        chk("sat_lo_up1_pred", prediction_F, 0);
        tick();
        idle_e();
        chk("sat_lo_up2_pred", prediction_F, 1);
        chk("sat_ghr_held", ghr_F, 0);

        // Same-cycle read/write of idx 7: install BTB via idx 6 first
        train(5'd7, 5'd1, 1'b1, 5'd25, 1'b0);
        tick();
        PC_F = 5'd7;
        train(5'd7, 5'd0, 1'b1, 5'd25, 1'b0);
        #1;
        chk("rw_same_cycle_pred", prediction_F, 0);
        tick();
        idle_e();
        chk("rw_next_cycle_pred", prediction_F, 1);
        chk("rw_bta", BTA_F, 25);

        // Move GHR to 1 then assert reset between edges
        train(5'd7, 5'd0, 1'b1, 5'd13, 1'b1);
        tick();
        idle_e();
        chk("pre_reset_ghr", ghr_F, 1);
        chk("pre_reset_bta", BTA_F, 13);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pred", prediction_F, 0);
        chk("async_reset_bta",  BTA_F, 0);
        chk("async_reset_ghr",  ghr_F, 0);
        train(5'd7, 5'd0, 1'b1, 5'd30, 1'b1);
        tick();
        idle_e();
        reset = 1'b0;
        #1;
        chk("reset_drops_train_bta", BTA_F, 0);
        chk("reset_drops_train_ghr", ghr_F, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
